// File: rtl/mac_dot_if.sv
// Operand/result stream bundle for the dot-product sequencer.
// The master side is the operand source and result consumer; the sequencer is the slave.
interface mac_dot_if #(
  parameter int LEN_W  = 4,
  parameter int DATA_W = 8
);
  logic                  start;
  logic [LEN_W-1:0]      len;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     a;
  logic [DATA_W-1:0]     b;
  logic                  res_valid;
  logic                  res_ready;
  logic [2*DATA_W-1:0]   result;
  logic                  ovf;
  logic                  busy;

  modport master (
    output start, len, in_valid, a, b, res_ready,
    input  in_ready, res_valid, result, ovf, busy
  );

  modport slave (
    input  start, len, in_valid, a, b, res_ready,
    output in_ready, res_valid, result, ovf, busy
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Start/length/done sequencer around an 8x8 multiply, 16-bit accumulate datapath.
// Operand pairs stream in one per cycle; the wrapped sum and a sticky carry flag come out.
module mac_dot_sequencer #(
  parameter int LEN_W = 4
) (
  input  logic      clk,
  input  logic      rst,
  mac_dot_if.slave  bus
);
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  cnt_r;
  logic              in_ready;
  logic              hs;
  logic              last_hs;
  logic              start_acc;

  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic              vld_p1;

  logic [ACC_W-1:0]  acc_p2;
  logic              ovf_p2;
  logic [ACC_W:0]    sum_p1;

  // Full-width product added to the accumulator; bit ACC_W is the carry out.
  function automatic logic [ACC_W:0] acc_add(
    input logic [ACC_W-1:0]  acc,
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] y
  );
    logic [ACC_W-1:0] prod;
    prod = {{(ACC_W-DATA_W){1'b0}}, x} * {{(ACC_W-DATA_W){1'b0}}, y};
    return {1'b0, acc} + {1'b0, prod};
  endfunction

  assign hs      = bus.in_valid & in_ready;
  // Counter is compared one bit wider so len = 2^LEN_W-1 never aliases to zero.
  assign last_hs = (({1'b0, cnt_r} + (LEN_W+1)'(1)) == {1'b0, len_r});
  assign sum_p1  = acc_add(acc_p2, a_p1, b_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          start_acc = 1'b1;
          state_d   = (bus.len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        in_ready = 1'b1;
        if (hs && last_hs) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stage p0 -> p1: operand capture on handshake, pair counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r  <= '0;
      cnt_r  <= '0;
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
    end else if (start_acc) begin
      len_r  <= bus.len;
      cnt_r  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= hs;
      if (hs) begin
        a_p1  <= bus.a;
        b_p1  <= bus.b;
        cnt_r <= cnt_r + LEN_W'(1);
      end
    end
  end

  // Stage p1 -> p2: multiply-accumulate; the accumulator doubles as the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (start_acc) begin
      acc_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (vld_p1) begin
      acc_p2 <= sum_p1[ACC_W-1:0];
      ovf_p2 <= ovf_p2 | sum_p1[ACC_W];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.res_valid = (state_q == S_DONE);
  assign bus.result    = acc_p2;
  assign bus.ovf       = ovf_p2;
  assign bus.busy      = (state_q != S_IDLE);

endmodule
